// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit: one shift-add or restoring-divide
// iteration per clock, XLEN iterations, start/busy/done handshake.
module mul_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out,
  output logic            div_by_zero
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_op;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_out;
  logic                r_dbz;

  logic                w_accept;
  logic                w_last;
  logic [XLEN:0]       w_madd;
  logic [2*XLEN-1:0]   w_mul_acc;
  logic [XLEN:0]       w_rsh;
  logic                w_fits;
  logic [XLEN-1:0]     w_sub;
  logic [2*XLEN-1:0]   w_div_acc;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]     w_result;

  // A start in DONE is taken exactly like one in IDLE; only RUN ignores it.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(XLEN - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shift-add: multiplier bits consumed from r_b LSB, product settles in r_acc.
  assign w_madd    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_mul_acc = {w_madd, r_acc[XLEN-1:1]};

  // Restoring divide: r_acc = {remainder, dividend->quotient}, r_b = divisor.
  // When the trial fits, the difference is below the divisor so XLEN bits suffice.
  assign w_rsh     = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_fits    = (w_rsh >= {1'b0, r_b});
  assign w_sub     = w_rsh[XLEN-1:0] - r_b;
  assign w_div_acc = w_fits ? {w_sub,            r_acc[XLEN-2:0], 1'b1}
                            : {w_rsh[XLEN-1:0],  r_acc[XLEN-2:0], 1'b0};

  assign w_acc_nxt = r_op[1] ? w_div_acc : w_mul_acc;

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = w_acc_nxt[XLEN-1:0];
      2'b01:   w_result = w_acc_nxt[2*XLEN-1:XLEN];
      2'b10:   w_result = w_acc_nxt[XLEN-1:0];
      default: w_result = w_acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= op;
        r_a   <= in1;
        r_b   <= in2;
        r_acc <= op[1] ? {{XLEN{1'b0}}, in1} : '0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (!r_op[1]) r_b <= r_b >> 1;
        if (w_last) begin
          r_out <= w_result;
          r_dbz <= r_op[1] && (r_b == '0);
        end
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign out         = r_out;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit for the RISC core; an area-saving alternative to the combinational 32x32 multiplier.
- Sequences one 32-iteration shift-add or restoring-divide datapath from a start/busy/done handshake.
- The core stalls its writeback on `busy` and captures `out` on `done`.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN; internal counter width is clog2(XLEN)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when not busy.
- op  input  2  operation code:
  - 00 MUL: low XLEN bits of product.
  - 01 MULHU: high XLEN bits of unsigned product.
  - 10 DIVU: quotient.
  - 11 REMU: remainder.
- in1  input  XLEN  multiplicand / dividend.
- in2  input  XLEN  multiplier / divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.
- out  output  XLEN  result; held stable from done until the next accepted start.
- div_by_zero  output  1  valid with done; set for op 10/11 when the latched in2 == 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, out=0, div_by_zero=0.
  - Counter and internal registers cleared.
  - Applies in every state, including mid-operation; the in-flight operation is discarded with no done pulse.
- States:
  - IDLE: start=1 -> latch op, in1, in2; clear the 2*XLEN accumulator and counter; go to RUN.
  - RUN: one iteration per clock; counter increments; when the counter reaches XLEN-1 at an edge, go to DONE on that edge.
  - DONE: done=1 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE (go to RUN; back-to-back issue allowed).
- Timing (edge E0 samples start):
  - busy=1 after E0 through E32, i.e. busy is high in RUN only.
  - Iterations execute at E1..E32.
  - After E32: state=DONE, done=1, out and div_by_zero valid.
  - At E33: done=0.
  - Fixed latency of 33 cycles from the start edge to done, independent of operand values.
- Handshake:
  - start while busy=1 is ignored (no restart, no queueing).
  - in1/in2/op may change freely after E0; only latched values are used.
- MUL/MULHU: unsigned shift-add. Per iteration, if the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator (XLEN+1-bit add, carry kept); then shift the accumulator right by 1.
- DIVU/REMU: restoring division. Per iteration:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor from the remainder (XLEN+1 bits).
  - If non-negative, commit and set the quotient bit to 1; else restore and set it to 0.
- Divide by zero follows naturally from the restoring algorithm: DIVU -> all ones, REMU -> dividend; div_by_zero=1. Latency is unchanged.
- out is updated only on the RUN->DONE edge; it retains its value through IDLE.
- div_by_zero is 0 for MUL/MULHU. It is updated on the same edge as out and held with it.

Test Plan:
- Reset then MUL: op=00, in1=7, in2=6, start one cycle -> busy high 32 cycles; done exactly 33 cycles after the start edge; out=42; div_by_zero=0.
- MUL/MULHU edge: in1=in2=0xFFFFFFFF -> MUL out=0x00000001; MULHU out=0xFFFFFFFE.
- DIVU/REMU: in1=100, in2=7 -> DIVU out=14, REMU out=2. Change in1/in2 to garbage the cycle after start -> results unchanged.
- Divide by zero: DIVU in1=5, in2=0 -> out=0xFFFFFFFF, div_by_zero=1; REMU in1=5, in2=0 -> out=5, div_by_zero=1; latency still 33 cycles.
- Handshake:
  - Pulse start again 5 cycles into a MUL 3*4 -> ignored; single done; out=12.
  - Assert start with DIVU 9/2 during the done cycle -> accepted; next done 33 cycles later with out=4.
- Reset mid-op: assert rst at iteration 10 of DIVU 1000/3 -> next cycle busy=0, done=0, out=0, and no done ever fires for it. A subsequent MUL 5*5 gives out=25 with normal latency.
